gt_compare_arbiter: RTL
=======================

Name: gt_compare_arbiter

Overview:
- Shares one W-bit unsigned greater-than comparator between N requesters.
- Arbitration is round-robin, with one comparison accepted per cycle.
- Results return through a two-stage pipeline, tagged one-hot to the owning requester.
- Sits in the ALU between the requesting control units and the 6-bit greater-than datapath, so the comparator is not replicated per client.

Parameters:
- N, 4, number of requesters (2..8).
- W, 6, operand width in bits (matches the 6-bit comparator datapath).
- CW, 16, width of the completed-comparison counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  N  request per requester. Held high, with operands stable, until ack.
- x_in  in  N*W  operand A per requester. Requester i uses bits [i*W +: W].
- y_in  in  N*W  operand B per requester, same packing as x_in.
- ack  out  N  one-hot, combinational. Operands of requester i are accepted this cycle.
- rsp_valid  out  N  one-hot, registered. Result for requester i is valid this cycle.
- rsp_gt  out  1  registered. 1 when A > B (unsigned) for the valid response.
- rsp_eq  out  1  registered. 1 when A == B for the valid response.
- busy  out  1  1 while any comparison is in flight (stage 1 or stage 2 valid).
- cmp_count  out  CW  number of completed comparisons. Wraps at 2^CW.

Behaviour:
- Reset (rst_n low at a clock edge):
  - ack, rsp_valid, rsp_gt, rsp_eq, busy and cmp_count all go to 0.
  - Round-robin pointer goes to 0, so requester 0 has highest priority.
  - Both pipeline valid bits clear.
  - Reset mid-operation drops in-flight comparisons; no rsp_valid is issued for them.
  - ack is forced to 0 while rst_n is low.
- Arbiter:
  - Each cycle, grant goes to the first asserted req scanning ptr, ptr+1, ... with wrap modulo N.
  - ack = one-hot grant, combinational from req and ptr.
  - On any grant to requester g, ptr <= (g+1) mod N. With no grant, ptr holds.
  - A single requester with req held high is accepted every cycle (back-to-back).
  - No starvation: a held req is granted within N cycles.
- Stage 1 (registered on accept): latches x, y, owner index and s1_valid. If nothing is accepted, s1_valid <= 0.
- Stage 2:
  - Comparator evaluates the stage-1 registers.
  - rsp_gt, rsp_eq and the one-hot rsp_valid[owner] register at the next edge; rsp_valid = 0 when s1_valid = 0.
  - rsp_gt and rsp_eq are don't-care-free: they are 0 when no response is valid.
- Latency: ack in cycle t gives rsp_valid in cycle t+2. Throughput is 1 comparison per cycle. No backpressure on responses.
- Ordering: responses leave in acceptance order. Several comparisons from one requester may be in flight at once.
- Arithmetic:
  - Unsigned compare on W bits.
  - x == y gives gt = 0, eq = 1.
  - Operand bits above W do not exist.
- cmp_count increments by 1 on every cycle with any rsp_valid bit set. It wraps from 2^CW-1 to 0.
- busy = s1_valid | (|rsp_valid).
- A req that drops without ack is simply not served; there is no error.

Decomposition:
- Shared package/header holds:
  - default N, W and CW;
  - the one-hot-to-index and index-to-one-hot helpers;
  - the response tag encoding.
- Sub-module gt_eq_compare: combinational W-bit unsigned comparator, inputs a and b, outputs gt and eq. It reuses the team's 2-bit-slice greater-than structure, generalised to W.
- The arbiter and pipeline registers stay in the top level.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then req = 0 for 5 cycles. All outputs stay 0 and cmp_count = 0.
- Single compare: req = 0001, x0 = 45, y0 = 12 in cycle t. ack = 0001 at t; at t+2, rsp_valid = 0001, rsp_gt = 1, rsp_eq = 0, cmp_count = 1.
- Equality and boundaries on requester 2:
  - x = 63, y = 63 gives gt = 0, eq = 1.
  - x = 0, y = 63 gives gt = 0, eq = 0.
  - x = 63, y = 0 gives gt = 1.
- Round-robin fairness: req = 1111 held 8 cycles. ack sequence is 0001, 0010, 0100, 1000, 0001, ...; each requester gets 2 responses; cmp_count = 8.
- Pointer wrap with sparse requests: after a grant to requester 3, req = 1001. Grant goes to requester 0 first, then 3 the next cycle; ptr returns to 0.
- Reset mid-flight: accept in cycle t, rst_n low in cycle t+1. No rsp_valid at t+2; busy = 0; cmp_count unchanged at 0.
- Counter wrap (CW = 4 build): 17 completed compares give cmp_count = 1.

Source files
------------

// File: rtl/gt_compare_arbiter_pkg.sv
// Shared defaults, index/one-hot helpers and response tag encoding for the
// shared greater-than comparator block.
package gt_compare_arbiter_pkg;

  localparam int N_DEF  = 4;
  localparam int W_DEF  = 6;
  localparam int CW_DEF = 16;

  // Helpers are sized for the largest supported requester count.
  localparam int MAX_N = 8;
  localparam int IDX_W = 3;

  // Comparator outcome as carried into the response stage:
  // bit 1 = greater-than, bit 0 = equal.
  typedef enum logic [1:0] {
    TAG_LT = 2'b00,
    TAG_EQ = 2'b01,
    TAG_GT = 2'b10
  } cmp_tag_e;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++)
      if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction

  function automatic logic [MAX_N-1:0] idx2oh(input logic [IDX_W-1:0] idx);
    return MAX_N'(1) << idx;
  endfunction

  function automatic cmp_tag_e mk_tag(input logic gt, input logic eq);
    if (gt)      return TAG_GT;
    else if (eq) return TAG_EQ;
    else         return TAG_LT;
  endfunction

endpackage

// File: rtl/gt_eq_compare.sv
// Combinational W-bit unsigned comparator built from 2-bit greater-than
// slices, combined from the most significant slice down.
module gt_eq_compare #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         eq
);

  localparam int S = (W + 1) / 2;

  // Odd widths are zero-padded to a whole number of slices.
  logic [2*S-1:0] ap, bp;
  logic [S-1:0]   sgt, seq;

  assign ap = (2*S)'(a);
  assign bp = (2*S)'(b);

  generate
    for (genvar s = 0; s < S; s++) begin : g_slice
      assign sgt[s] = (ap[2*s+1] & ~bp[2*s+1]) |
                      (~(ap[2*s+1] ^ bp[2*s+1]) & ap[2*s] & ~bp[2*s]);
      assign seq[s] = (ap[2*s+1:2*s] == bp[2*s+1:2*s]);
    end
  endgenerate

  // First unequal slice from the top decides; all-equal means eq.
  always_comb begin
    gt = 1'b0;
    eq = 1'b1;
    for (int s = S - 1; s >= 0; s--) begin
      gt = gt | (eq & sgt[s]);
      eq = eq & seq[s];
    end
  end

endmodule

// File: rtl/gt_compare_arbiter.sv
// Round-robin arbiter sharing one comparator between N requesters, with a
// two-stage pipeline returning one-hot tagged results.
module gt_compare_arbiter
  import gt_compare_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  x_in,
  input  logic [N*W-1:0]  y_in,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    rsp_valid,
  output logic            rsp_gt,
  output logic            rsp_eq,
  output logic            busy,
  output logic [CW-1:0]   cmp_count
);

  logic [IDX_W-1:0] ptr, ptr_nxt, gidx;
  logic [N-1:0]     grant;
  logic [W-1:0]     s1_x, s1_y;
  logic [IDX_W-1:0] s1_own;
  logic             s1_valid;
  logic             c_gt, c_eq;
  cmp_tag_e         tag;

  // Round-robin scan starting at ptr, wrapping modulo N.
  always_comb begin
    int  j;
    logic found;
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign gidx    = oh2idx(MAX_N'(grant));
  assign ptr_nxt = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
  assign ack     = rst_n ? grant : '0;

  gt_eq_compare #(.W(W)) u_cmp (
    .a  (s1_x),
    .b  (s1_y),
    .gt (c_gt),
    .eq (c_eq)
  );

  assign tag  = mk_tag(c_gt, c_eq);
  assign busy = s1_valid | (|rsp_valid);

  // Accept stage, response stage and completion counter. Reset drops any
  // comparison in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_own    <= '0;
      s1_valid  <= 1'b0;
      rsp_valid <= '0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
      cmp_count <= '0;
    end else begin
      if (|grant) begin
        ptr      <= ptr_nxt;
        s1_x     <= x_in[gidx*W +: W];
        s1_y     <= y_in[gidx*W +: W];
        s1_own   <= gidx;
        s1_valid <= 1'b1;
      end else begin
        s1_valid <= 1'b0;
      end
      rsp_valid <= s1_valid ? N'(idx2oh(s1_own)) : '0;
      rsp_gt    <= s1_valid & (tag == TAG_GT);
      rsp_eq    <= s1_valid & (tag == TAG_EQ);
      // Counts the response being registered, so it matches rsp_valid.
      cmp_count <= cmp_count + CW'(s1_valid);
    end
  end

endmodule
